// File: rtl/d_mem_ring_rsp_pkg.sv
// Shared types and sizes for the ring-side data-memory responder.
// Ring opcodes, responder FSM states and the default field widths.
package d_mem_ring_rsp_pkg;

    localparam int unsigned MSB_D_MEM    = 11;
    localparam int unsigned D_MEM_ADDR_W = MSB_D_MEM + 1;
    localparam int unsigned RING_SRC_W   = 8;

    typedef enum logic [1:0] {
        RING_RD     = 2'd0,
        RING_WR     = 2'd1,
        RING_RD_RSP = 2'd2,
        RING_WR_ACK = 2'd3
    } t_ring_opcode;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RSP     = 2'd2
    } t_rsp_state;

    // Only RD and WR are legal as requests; response opcodes arriving here are dropped.
    function automatic logic is_mem_req(input t_ring_opcode op);
        return (op == RING_RD) || (op == RING_WR);
    endfunction

endpackage

// File: rtl/d_mem_ring_rsp_if.sv
// Ring request/response channel between a ring stop (master) and the d_mem responder (slave).
interface d_mem_ring_rsp_if #(
    parameter int unsigned SRC_W  = d_mem_ring_rsp_pkg::RING_SRC_W,
    parameter int unsigned ADDR_W = d_mem_ring_rsp_pkg::D_MEM_ADDR_W
);
    import d_mem_ring_rsp_pkg::*;

    logic               req_valid;
    logic               req_ready;
    t_ring_opcode       req_opcode;
    logic [ADDR_W-1:0]  req_address;
    logic [31:0]        req_data;
    logic [3:0]         req_byteena;
    logic [SRC_W-1:0]   req_src;

    logic               rsp_valid;
    logic               rsp_ready;
    t_ring_opcode       rsp_opcode;
    logic [ADDR_W-1:0]  rsp_address;
    logic [31:0]        rsp_data;
    logic [SRC_W-1:0]   rsp_src;

    modport master (
        output req_valid, req_opcode, req_address, req_data, req_byteena, req_src,
        input  req_ready,
        input  rsp_valid, rsp_opcode, rsp_address, rsp_data, rsp_src,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_opcode, req_address, req_data, req_byteena, req_src,
        output req_ready,
        output rsp_valid, rsp_opcode, rsp_address, rsp_data, rsp_src,
        input  rsp_ready
    );

endinterface

// File: rtl/d_mem_ring_rsp.sv
// Ring-side responder owning port b of the data memory; hides the one-cycle read latency.
// Optional LOTR_RING_WR_ACK_EN: writes return a RING_WR_ACK instead of being posted.
module d_mem_ring_rsp
    import d_mem_ring_rsp_pkg::*;
#(
    parameter int unsigned SRC_W  = RING_SRC_W,
    parameter int unsigned ADDR_W = D_MEM_ADDR_W
) (
    input  logic              clock,
    input  logic              rst_n,
    d_mem_ring_rsp_if.slave   ring,
    output logic [ADDR_W-3:0] address_b,
    output logic [3:0]        byteena_b,
    output logic [31:0]       data_b,
    output logic              rden_b,
    output logic              wren_b,
    input  logic [31:0]       q_b
);

    t_rsp_state         state_q, state_d;
    logic               rsp_valid_q, rsp_valid_d;
    t_ring_opcode       rsp_opcode_q, rsp_opcode_d;
    logic [ADDR_W-1:0]  rsp_address_q, rsp_address_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [SRC_W-1:0]   rsp_src_q, rsp_src_d;
    logic               accept;

    assign ring.req_ready = (state_q == S_IDLE);

    // Gated by rst_n so a request presented during reset never reaches the memory.
    assign accept = ring.req_valid && ring.req_ready && rst_n;

    assign address_b = ring.req_address[ADDR_W-1:2];
    assign byteena_b = ring.req_byteena;
    assign data_b    = ring.req_data;
    assign rden_b    = accept && (ring.req_opcode == RING_RD);
    assign wren_b    = accept && (ring.req_opcode == RING_WR);

    assign ring.rsp_valid   = rsp_valid_q;
    assign ring.rsp_opcode  = rsp_opcode_q;
    assign ring.rsp_address = rsp_address_q;
    assign ring.rsp_data    = rsp_data_q;
    assign ring.rsp_src     = rsp_src_q;

    always_comb begin
        state_d       = state_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_opcode_d  = rsp_opcode_q;
        rsp_address_d = rsp_address_q;
        rsp_data_d    = rsp_data_q;
        rsp_src_d     = rsp_src_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept && is_mem_req(ring.req_opcode)) begin
                    if (ring.req_opcode == RING_RD) begin
                        rsp_address_d = ring.req_address;
                        rsp_src_d     = ring.req_src;
                        state_d       = S_RD_WAIT;
                    end else begin
`ifdef LOTR_RING_WR_ACK_EN
                        rsp_address_d = ring.req_address;
                        rsp_src_d     = ring.req_src;
                        rsp_opcode_d  = RING_WR_ACK;
                        rsp_data_d    = 32'h0;
                        rsp_valid_d   = 1'b1;
                        state_d       = S_RSP;
`endif
                    end
                end
            end
            S_RD_WAIT: begin
                // q_b is valid exactly one cycle after rden_b.
                rsp_data_d   = q_b;
                rsp_opcode_d = RING_RD_RSP;
                rsp_valid_d  = 1'b1;
                state_d      = S_RSP;
            end
            S_RSP: begin
                if (ring.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_opcode_q  <= RING_RD_RSP;
            rsp_address_q <= '0;
            rsp_data_q    <= 32'h0;
            rsp_src_q     <= '0;
        end else begin
            state_q       <= state_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_opcode_q  <= rsp_opcode_d;
            rsp_address_q <= rsp_address_d;
            rsp_data_q    <= rsp_data_d;
            rsp_src_q     <= rsp_src_d;
        end
    end

endmodule
